// File: rtl/seg_mux_n.sv
// Multiplexed N-digit 7-segment driver, active-low segments/dp/enables.
// Optional per-digit blinking when SEG_BLINK_EN is defined.
module seg_mux_n #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int BLINK_SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] nums,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink,
`endif
    output logic [6:0]              display,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 ||
        BLINK_SHIFT < 0 || BLINK_SHIFT > 30) begin : g_bad_cfg
        $error("seg_mux_n: illegal parameter value");
    end

    logic [DIV_WIDTH-1:0] div;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_nxt;
    logic                 started;
    logic                 tick;
    logic                 hide;
    logic [3:0]           code;

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b0010010;
            4'hC:    decode = 7'b1000110;
            4'hD:    decode = 7'b0111111;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign tick = &div;

    // First tick after reset lands on index 0 rather than advancing.
    always_comb begin
        idx_nxt = '0;
        if (started && idx != LAST)
            idx_nxt = idx + 1'b1;
    end

    assign code = nums[{idx_nxt, 2'b00} +: 4];

`ifdef SEG_BLINK_EN
    logic [BLINK_SHIFT:0] frame;
    logic [BLINK_SHIFT:0] frame_nxt;

    // Phase is taken from the frame being entered, so a blink
    // boundary applies from digit 0 of the new frame onward.
    assign frame_nxt = (started && idx == LAST) ? frame + 1'b1 : frame;
    assign hide = blank[idx_nxt] |
                  (blink[idx_nxt] & frame_nxt[BLINK_SHIFT]);
`else
    assign hide = blank[idx_nxt];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            idx     <= '0;
            started <= 1'b0;
            digit   <= '1;
            display <= 7'b1111111;
            dp      <= 1'b1;
`ifdef SEG_BLINK_EN
            frame   <= '0;
`endif
        end else begin
            div <= div + 1'b1;
            if (tick) begin
                idx     <= idx_nxt;
                started <= 1'b1;
                digit   <= ~(NUM_DIGITS'(1) << idx_nxt);
                display <= hide ? 7'b1111111 : decode(code);
                dp      <= hide ? 1'b1 : ~dp_in[idx_nxt];
`ifdef SEG_BLINK_EN
                frame   <= frame_nxt;
`endif
            end
        end
    end

endmodule

// File: doc/seg_mux_n.md
SEG_MUX_N -- requirements
Module: seg_mux_n

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 The block SHALL have parameter DIV_WIDTH, default 16, refresh-divider width; one scan tick every 2^DIV_WIDTH clk cycles.
REQ-003 The block SHALL have parameter BLINK_SHIFT, default 6, blink half-period of 2^BLINK_SHIFT full scan frames (used only with SEG_BLINK_EN).
REQ-004 The block SHALL have port clk, input, 1, single clock for all state.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port nums, input, 4*NUM_DIGITS, one hex code per digit; digit i uses nums[4i+3:4i].
REQ-007 The block SHALL have port dp_in, input, NUM_DIGITS, decimal point request per digit, 1 = lit.
REQ-008 The block SHALL have port blank, input, NUM_DIGITS, per-digit forced blank, 1 = dark.
REQ-009 The block SHALL have port blink, input, NUM_DIGITS, per-digit blink enable (present only with SEG_BLINK_EN).
REQ-010 The block SHALL have port display, output, 7, registered segments g..a, active-low.
REQ-011 The block SHALL have port dp, output, 1, registered decimal point, active-low.
REQ-012 The block SHALL have port digit, output, NUM_DIGITS, registered digit enables, active-low, at most one low.

Function
REQ-013 The block SHALL use a free-running DIV_WIDTH-bit divider that increments every clk and wraps; tick is asserted in the cycle the divider equals all-ones.
REQ-014 The block SHALL hold a scan index 0..NUM_DIGITS-1 plus a "started" flag; on the first tick after reset it SHALL select index 0 and set started; on later ticks it SHALL advance index by one, wrapping NUM_DIGITS-1 -> 0.
REQ-015 On the clk edge ending a tick cycle, digit, display and dp SHALL all update together for the new index, so segments never lead or lag the enable.
REQ-016 nums, dp_in, blank (and blink) SHALL be sampled only at that edge; changes between ticks SHALL have no effect until the next tick.
REQ-017 Decode SHALL be: 0..9 standard (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000), A(1010)=0001000, S(1011)=0010010, C(1100)=1000110, dash(1101)=0111111, 1110 and 1111 = 1111111.
REQ-018 When the selected digit's blank bit is 1, display SHALL be 1111111 and dp 1, while digit still enables that position.
REQ-019 dp SHALL be the inverse of dp_in for the selected digit unless blanked.
REQ-020 Latency from rst deassertion to first enabled digit SHALL be exactly 2^DIV_WIDTH clk cycles.

Reset
REQ-021 While rst is high at a clk edge: divider = 0, index = 0, started = 0, digit = all ones, display = 1111111, dp = 1, blink phase = 0.
REQ-022 Reset asserted mid-scan SHALL darken all digits at the next edge and restart the latency of REQ-020.

Configuration
REQ-023 With macro SEG_BLINK_EN defined: port blink exists; a frame counter increments when index wraps NUM_DIGITS-1 -> 0, and its bit BLINK_SHIFT is the blink phase; a digit with blink = 1 SHALL be blanked as in REQ-018 while phase = 1.
REQ-024 Without SEG_BLINK_EN: no blink port, no frame counter, behaviour exactly as REQ-013..REQ-022.

Verification (NUM_DIGITS=4, DIV_WIDTH=2)
REQ-025 rst 1 for 3 cycles then 0, nums=16'h4321 -> digit=1111 for cycles 1..3, at cycle 4 digit=1110 display=1111001, then 1101/0100100, 1011/0110000, 0111/0011001 every 4 cycles, then wraps to 1110.
REQ-026 nums=16'hDCBA, dp_in=4'b0101 -> codes A,S,C,dash shown on digits 0..3; dp=0 on digits 0 and 2, 1 on digits 1 and 3.
REQ-027 blank=4'b0010, nums=16'h8888 -> digit1 shows 1111111 with dp 1 while digit=1101; others 0000000.
REQ-028 Change nums mid-dwell (2 cycles after a tick) -> display unchanged until next tick edge.
REQ-029 rst pulsed 1 cycle while digit=1011 -> next edge digit=1111 display=1111111; first re-enable 4 cycles after rst drops, digit=1110.
REQ-030 SEG_BLINK_EN, BLINK_SHIFT=1, blink=4'b0001, nums=16'h0000 -> digit0 shows 1000000 for frames 0-1, 1111111 for frames 2-3, repeating; digits 1..3 steady 1000000.
